// File: rtl/sysbus_ctrl.sv
// sysbus_ctrl
// Shares the single RAM port between the CPU and the DMA engine.
//
// Bus ownership changes hands only at a CPU instruction boundary. While the
// DMA owns the bus, the CPU is stalled. When the DMA hands the bus back, one
// turnaround cycle is inserted with all RAM lines driven low. After that, the
// CPU is guaranteed CPU_SLICE cycles of ownership before the next grant.
// A sticky error flag records any DMA strobe driven without a grant.
//
// Ports
//   Clk, Rst_n                   clock (rising edge), async active-low reset
//   Cpu_Address/DataOut          CPU address and write data (8 bits each)
//   Cpu_Cs/Wen/Oen               CPU RAM strobes, active-high
//   Cpu_Boundary                 CPU is at an instruction boundary
//   Cpu_Hold                     CPU stall (DMA_OWN and RETURN)
//   Dma_Address/DataOut          DMA address and write data (8 bits each)
//   Dma_Cs/Wen/Oen               DMA RAM strobes, active-high
//   Bus_req / Bus_grant          DMA request level / grant (DMA_OWN only)
//   Ram_Address/DataIn           muxed address and write data to RAM
//   Ram_Cs/Wen/Oen               muxed RAM strobes
//   Err_Clr / Bus_Err            clear / sticky ungranted-strobe flag
module sysbus_ctrl #(
  parameter int CPU_SLICE = 4
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [7:0] Cpu_Address,
  input  logic [7:0] Cpu_DataOut,
  input  logic       Cpu_Cs,
  input  logic       Cpu_Wen,
  input  logic       Cpu_Oen,
  input  logic       Cpu_Boundary,
  output logic       Cpu_Hold,
  input  logic [7:0] Dma_Address,
  input  logic [7:0] Dma_DataOut,
  input  logic       Dma_Cs,
  input  logic       Dma_Wen,
  input  logic       Dma_Oen,
  input  logic       Bus_req,
  output logic       Bus_grant,
  output logic [7:0] Ram_Address,
  output logic [7:0] Ram_DataIn,
  output logic       Ram_Cs,
  output logic       Ram_Wen,
  output logic       Ram_Oen,
  input  logic       Err_Clr,
  output logic       Bus_Err
);

  // Slice counter width: $clog2(CPU_SLICE+1), but never less than 1 bit.
  localparam int CNT_W = (CPU_SLICE > 0) ? $clog2(CPU_SLICE + 1) : 1;
  localparam logic [CNT_W-1:0] SLICE_LOAD =
    (CPU_SLICE > 0) ? CNT_W'(CPU_SLICE - 1) : '0;

  typedef enum logic [2:0] {
    CPU_OWN  = 3'd0,
    WAIT_BND = 3'd1,
    DMA_OWN  = 3'd2,
    RETURN   = 3'd3,
    SLICE    = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             dma_strobe;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= CPU_OWN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CPU_OWN:  if (Bus_req) state_nxt = WAIT_BND;
      WAIT_BND: begin
        // A withdrawn request takes priority over a coincident boundary.
        if (!Bus_req)          state_nxt = CPU_OWN;
        else if (Cpu_Boundary) state_nxt = DMA_OWN;
      end
      DMA_OWN:  if (!Bus_req) state_nxt = RETURN;
      RETURN: begin
        if (CPU_SLICE > 0) begin
          state_nxt = SLICE;
          cnt_nxt   = SLICE_LOAD;
        end else begin
          state_nxt = CPU_OWN;
        end
      end
      SLICE: begin
        // Bus_req is deliberately ignored until the slice runs out.
        if (cnt == '0) state_nxt = CPU_OWN;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default:  state_nxt = CPU_OWN;
    endcase
  end

  // Grant and hold are decoded from the state register alone, so they are
  // glitch-free and drop as soon as reset is asserted.
  assign Bus_grant = (state == DMA_OWN);
  assign Cpu_Hold  = (state == DMA_OWN) || (state == RETURN);

  always_comb begin
    Ram_Address = Cpu_Address;
    Ram_DataIn  = Cpu_DataOut;
    Ram_Cs      = Cpu_Cs;
    Ram_Wen     = Cpu_Wen;
    Ram_Oen     = Cpu_Oen;
    case (state)
      DMA_OWN: begin
        Ram_Address = Dma_Address;
        Ram_DataIn  = Dma_DataOut;
        Ram_Cs      = Dma_Cs;
        Ram_Wen     = Dma_Wen;
        Ram_Oen     = Dma_Oen;
      end
      RETURN: begin
        Ram_Address = '0;
        Ram_DataIn  = '0;
        Ram_Cs      = 1'b0;
        Ram_Wen     = 1'b0;
        Ram_Oen     = 1'b0;
      end
      default: ;
    endcase
  end

  assign dma_strobe = Dma_Cs | Dma_Wen | Dma_Oen;

  // A violation in the same cycle as Err_Clr keeps the flag set.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                               Bus_Err <= 1'b0;
    else if (dma_strobe && state != DMA_OWN)  Bus_Err <= 1'b1;
    else if (Err_Clr)                         Bus_Err <= 1'b0;
  end

endmodule

// File: tb/tb_sysbus_ctrl.sv
module tb_sysbus_ctrl;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic [7:0] Cpu_Address, Cpu_DataOut, Dma_Address, Dma_DataOut;
  logic       Cpu_Cs, Cpu_Wen, Cpu_Oen, Cpu_Boundary;
  logic       Dma_Cs, Dma_Wen, Dma_Oen, Bus_req, Err_Clr;
  logic       Cpu_Hold, Bus_grant, Bus_Err;
  logic [7:0] Ram_Address, Ram_DataIn;
  logic       Ram_Cs, Ram_Wen, Ram_Oen;

  int n_tests = 0;
  int n_fail  = 0;

  sysbus_ctrl #(.CPU_SLICE(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .Cpu_Address(Cpu_Address), .Cpu_DataOut(Cpu_DataOut),
    .Cpu_Cs(Cpu_Cs), .Cpu_Wen(Cpu_Wen), .Cpu_Oen(Cpu_Oen),
    .Cpu_Boundary(Cpu_Boundary), .Cpu_Hold(Cpu_Hold),
    .Dma_Address(Dma_Address), .Dma_DataOut(Dma_DataOut),
    .Dma_Cs(Dma_Cs), .Dma_Wen(Dma_Wen), .Dma_Oen(Dma_Oen),
    .Bus_req(Bus_req), .Bus_grant(Bus_grant),
    .Ram_Address(Ram_Address), .Ram_DataIn(Ram_DataIn),
    .Ram_Cs(Ram_Cs), .Ram_Wen(Ram_Wen), .Ram_Oen(Ram_Oen),
    .Err_Clr(Err_Clr), .Bus_Err(Bus_Err)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs set after this belong to the new cycle.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst_n = 1'b0;
    Cpu_Address = 8'h00; Cpu_DataOut = 8'h00; Cpu_Cs = 0; Cpu_Wen = 0; Cpu_Oen = 0;
    Cpu_Boundary = 0; Dma_Address = 8'h00; Dma_DataOut = 8'h00;
    Dma_Cs = 0; Dma_Wen = 0; Dma_Oen = 0; Bus_req = 0; Err_Clr = 0;
    #3;
    check("rst_grant", {7'b0, Bus_grant}, 8'h00);
    check("rst_hold",  {7'b0, Cpu_Hold},  8'h00);
    check("rst_err",   {7'b0, Bus_Err},   8'h00);
    Cpu_Cs = 1; Cpu_Address = 8'h3C; Cpu_DataOut = 8'h11;
    #1;
    check("rst_ram_cs",   {7'b0, Ram_Cs}, 8'h01);
    check("rst_ram_addr", Ram_Address,    8'h3C);
    tick();
    Rst_n = 1'b1;

    // CPU owns the bus with no request.
    for (int k = 0; k < 4; k++) begin
      tick();
      check("idle_grant", {7'b0, Bus_grant}, 8'h00);
      check("idle_hold",  {7'b0, Cpu_Hold},  8'h00);
    end
    check("idle_ram_addr", Ram_Address, 8'h3C);

    // Request at t, boundary high only at t+5 -> grant at t+6.
    Bus_req = 1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("wait_grant", {7'b0, Bus_grant}, 8'h00);
      check("wait_hold",  {7'b0, Cpu_Hold},  8'h00);
      if (k == 5) Cpu_Boundary = 1;
    end
    tick();
    check("grant_t6", {7'b0, Bus_grant}, 8'h01);
    check("hold_t6",  {7'b0, Cpu_Hold},  8'h01);
    Dma_Address = 8'h80; Dma_Wen = 1; Dma_DataOut = 8'h5A;
    #1;
    check("dma_ram_addr", Ram_Address,     8'h80);
    check("dma_ram_wen",  {7'b0, Ram_Wen}, 8'h01);
    check("dma_ram_cs",   {7'b0, Ram_Cs},  8'h00);
    check("dma_ram_data", Ram_DataIn,      8'h5A);
    tick();
    check("dma_no_err", {7'b0, Bus_Err}, 8'h00);

    // Release at r, re-request at r+1 -> RETURN at r+1, grant again at r+8.
    Bus_req = 0; Dma_Wen = 0;
    tick();
    Bus_req = 1;
    #1;
    check("ret_grant", {7'b0, Bus_grant}, 8'h00);
    check("ret_hold",  {7'b0, Cpu_Hold},  8'h01);
    check("ret_cs",    {7'b0, Ram_Cs},    8'h00);
    check("ret_addr",  Ram_Address,       8'h00);
    check("ret_data",  Ram_DataIn,        8'h00);
    tick();
    check("r2_hold", {7'b0, Cpu_Hold}, 8'h00);
    check("r2_addr", Ram_Address,      8'h3C);
    for (int k = 3; k <= 7; k++) begin
      tick();
      check("slice_grant", {7'b0, Bus_grant}, 8'h00);
    end
    tick();
    check("regrant_r8", {7'b0, Bus_grant}, 8'h01);

    // Drop the bus and let the slice run out.
    Bus_req = 0; Cpu_Boundary = 0;
    for (int k = 0; k < 7; k++) tick();

    // Single-cycle request pulse without boundary: no grant.
    Bus_req = 1;
    tick();
    Bus_req = 0;
    check("pulse_grant1", {7'b0, Bus_grant}, 8'h00);
    Cpu_Boundary = 1;
    tick();
    check("pulse_grant2", {7'b0, Bus_grant}, 8'h00);
    tick();
    check("pulse_grant3", {7'b0, Bus_grant}, 8'h00);

    // Boundary already high in CPU_OWN does not shortcut the 2-cycle path.
    Bus_req = 1;
    tick();
    check("bnd_early", {7'b0, Bus_grant}, 8'h00);
    tick();
    check("bnd_grant", {7'b0, Bus_grant}, 8'h01);
    Bus_req = 0; Cpu_Boundary = 0;
    for (int k = 0; k < 7; k++) tick();

    // Ungranted DMA strobe sets the sticky error.
    Dma_Cs = 1;
    tick();
    Dma_Cs = 0;
    check("err_set", {7'b0, Bus_Err}, 8'h01);
    tick();
    check("err_sticky", {7'b0, Bus_Err}, 8'h01);
    Err_Clr = 1;
    tick();
    Err_Clr = 0;
    check("err_clr", {7'b0, Bus_Err}, 8'h00);
    Dma_Oen = 1;
    tick();
    check("err_set2", {7'b0, Bus_Err}, 8'h01);
    Err_Clr = 1;
    tick();
    check("err_set_wins", {7'b0, Bus_Err}, 8'h01);
    Dma_Oen = 0;
    tick();
    Err_Clr = 0;
    check("err_clr2", {7'b0, Bus_Err}, 8'h00);

    // Async reset during DMA_OWN.
    Bus_req = 1;
    tick();
    Cpu_Boundary = 1;
    tick();
    check("pre_rst_grant", {7'b0, Bus_grant}, 8'h01);
    Dma_Address = 8'h80;
    #2;
    Rst_n = 0;
    #1;
    check("arst_grant", {7'b0, Bus_grant}, 8'h00);
    check("arst_hold",  {7'b0, Cpu_Hold},  8'h00);
    check("arst_addr",  Ram_Address,       8'h3C);
    tick();
    Rst_n = 1;
    tick();
    check("post_rst_g1", {7'b0, Bus_grant}, 8'h00);
    tick();
    check("post_rst_g2", {7'b0, Bus_grant}, 8'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
